// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch PC sequencer with run/halt, stall and retired count (optional PC_REDIRECT_COUNT_EN)
module pc_sequencer #(
  parameter int                     PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [5:0]             HALT_OPCODE = 6'h3F
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stall,
  input  logic [31:0]         instruction,
  input  logic                branch,
  input  logic                zero,
  input  logic                jump,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic                fetch_valid,
  output logic                halted,
`ifdef PC_REDIRECT_COUNT_EN
  output logic [15:0]         redirect_count,
`endif
  output logic [15:0]         instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         br_sum;
  logic [PC_WIDTH-1:0] br_target;
  logic                redirect;
`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0]         rcnt_q, rcnt_d;
`endif

  // Branch target is PC+1 plus the sign-extended 16-bit offset, wrapped to PC_WIDTH.
  always_comb begin
    br_sum    = {{(32-PC_WIDTH){1'b0}}, pc_q} + 32'd1 + {{16{instruction[15]}}, instruction[15:0]};
    br_target = br_sum[PC_WIDTH-1:0];
  end

  // Next-state, next-PC and counter update; halt beats jump beats taken branch beats sequential.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    redirect = 1'b0;
`ifdef PC_REDIRECT_COUNT_EN
    rcnt_d   = rcnt_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          cnt_d   = '0;
`ifdef PC_REDIRECT_COUNT_EN
          rcnt_d  = '0;
`endif
        end
      end
      S_RUN: begin
        if (!stall) begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (instruction[31:26] == HALT_OPCODE) begin
            state_d = S_HALT;
          end else if (jump) begin
            pc_d     = instruction[PC_WIDTH-1:0];
            redirect = 1'b1;
          end else if (branch && zero) begin
            pc_d     = br_target;
            redirect = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
`ifdef PC_REDIRECT_COUNT_EN
          if (redirect && rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC and counter registers; asynchronous reset aborts any run in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
`ifdef PC_REDIRECT_COUNT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
`ifdef PC_REDIRECT_COUNT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  assign program_counter = pc_q;
  assign fetch_valid     = (state_q == S_RUN);
  assign halted          = (state_q == S_HALT);
  assign instr_count     = cnt_q;
`ifdef PC_REDIRECT_COUNT_EN
  assign redirect_count  = rcnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        stall;
  logic [31:0] instruction;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [7:0]  program_counter;
  logic        fetch_valid;
  logic        halted;
  logic [15:0] instr_count;
`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0] redirect_count;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .stall           (stall),
    .instruction     (instruction),
    .branch          (branch),
    .zero            (zero),
    .jump            (jump),
    .program_counter (program_counter),
    .fetch_valid     (fetch_valid),
    .halted          (halted),
`ifdef PC_REDIRECT_COUNT_EN
    .redirect_count  (redirect_count),
`endif
    .instr_count     (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_core(input string tag, input logic [7:0] pc, input logic fv,
                            input logic hl, input logic [15:0] cnt);
    check({tag, "_pc"},  {24'h0, program_counter}, {24'h0, pc});
    check({tag, "_fv"},  {31'h0, fetch_valid},     {31'h0, fv});
    check({tag, "_hlt"}, {31'h0, halted},          {31'h0, hl});
    check({tag, "_cnt"}, {16'h0, instr_count},     {16'h0, cnt});
  endtask

  task automatic check_redir(input string tag, input logic [15:0] exp);
`ifdef PC_REDIRECT_COUNT_EN
    check({tag, "_redir"}, {16'h0, redirect_count}, {16'h0, exp});
`else
    if (exp == 16'hFFFF) $display("unused %s", tag);
`endif
  endtask

  task automatic do_jump(input logic [7:0] tgt);
    instruction = {24'h0, tgt};
    jump = 1'b1; branch = 1'b0; zero = 1'b0;
    step();
    jump = 1'b0;
    instruction = 32'h0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stall = 1'b0;
    instruction = 32'h0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    #12;
    check_core("reset", 8'h00, 1'b0, 1'b0, 16'd0);
    check_redir("reset", 16'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // idle holds without start
    step();
    check_core("idle_hold", 8'h00, 1'b0, 1'b0, 16'd0);

    // start
    start = 1'b1;
    step();
    start = 1'b0;
    check_core("start", 8'h00, 1'b1, 1'b0, 16'd0);

    // three sequential instructions
    step(); check_core("seq1", 8'h01, 1'b1, 1'b0, 16'd1);
    step(); check_core("seq2", 8'h02, 1'b1, 1'b0, 16'd2);
    step(); check_core("seq3", 8'h03, 1'b1, 1'b0, 16'd3);

    // start held in RUN is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    check_core("start_in_run", 8'h04, 1'b1, 1'b0, 16'd4);

    // taken backward branch at PC=4: 4+1-3 = 2
    instruction = 32'h0000_FFFD; branch = 1'b1; zero = 1'b1;
    step();
    branch = 1'b0; zero = 1'b0;
    check_core("br_taken", 8'h02, 1'b1, 1'b0, 16'd5);
    check_redir("br_taken", 16'd1);

    // back to 4, branch not taken -> 5
    do_jump(8'h04);
    check_core("jump4", 8'h04, 1'b1, 1'b0, 16'd6);
    instruction = 32'h0000_FFFD; branch = 1'b1; zero = 1'b0;
    step();
    branch = 1'b0;
    check_core("br_not_taken", 8'h05, 1'b1, 1'b0, 16'd7);
    check_redir("br_not_taken", 16'd2);

    // forward branch at 250: 250+1+3 = 254
    do_jump(8'd250);
    instruction = 32'h0000_0003; branch = 1'b1; zero = 1'b1;
    step();
    branch = 1'b0; zero = 1'b0;
    check_core("br_fwd", 8'd254, 1'b1, 1'b0, 16'd9);
    check_redir("br_fwd", 16'd4);

    // jump beats branch at PC=10 (branch would go to 75)
    do_jump(8'd10);
    instruction = 32'h0000_0040; jump = 1'b1; branch = 1'b1; zero = 1'b1;
    step();
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    check_core("jump_prio", 8'h40, 1'b1, 1'b0, 16'd11);
    check_redir("jump_prio", 16'd6);

    // stall at 0xFF for three cycles, with jump and start present but ignored
    do_jump(8'hFF);
    stall = 1'b1; jump = 1'b1; start = 1'b1; instruction = 32'h0000_0055;
    for (int i = 0; i < 3; i++) begin
      step();
      check_core("stall", 8'hFF, 1'b1, 1'b0, 16'd12);
    end
    stall = 1'b0; jump = 1'b0; start = 1'b0; instruction = 32'h0;
    check_redir("stall", 16'd7);
    step();
    check_core("wrap", 8'h00, 1'b1, 1'b0, 16'd13);

    // halt at PC=7; jump/branch on the halt word are ignored
    do_jump(8'd7);
    instruction = {6'h3F, 26'h0000_012}; jump = 1'b1; branch = 1'b1; zero = 1'b1;
    step();
    jump = 1'b0; branch = 1'b0; zero = 1'b0; instruction = 32'h0;
    check_core("halt", 8'd7, 1'b0, 1'b1, 16'd15);
    check_redir("halt", 16'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      check_core("halt_hold", 8'd7, 1'b0, 1'b1, 16'd15);
    end

    // restart from HALT
    start = 1'b1;
    step();
    start = 1'b0;
    check_core("restart", 8'h00, 1'b1, 1'b0, 16'd0);
    check_redir("restart", 16'd0);

    // async reset mid-run at PC=12
    do_jump(8'd12);
    check_core("pre_rst", 8'd12, 1'b1, 1'b0, 16'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_core("async_rst", 8'h00, 1'b0, 1'b0, 16'd0);
    check_redir("async_rst", 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check_core("post_rst_idle", 8'h00, 1'b0, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-fetch sequencer that drives program_counter into the single-cycle core and instruction memory.
- Takes the fetched instruction word and the core's zero/branch/jump decode, then computes the next PC (sequential, branch, jump).
- Adds run/halt control, stall hold and a retired-instruction counter, so the core no longer needs a bench-supplied PC per line.

Parameters:
- PC_WIDTH, 8, width of program_counter; word-addressed instruction memory index.
- RESET_PC, 0, PC loaded on reset and on restart.
- HALT_OPCODE, 6'h3F, instruction[31:26] value that terminates execution.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level; begins/restarts execution when sampled in IDLE or HALT.
- stall  input  1  holds PC and counters for this cycle.
- instruction  input  32  current fetched word (combinational from instruction memory at program_counter).
- branch  input  1  control-unit Branch for current instruction.
- zero  input  1  ALU zero flag for current instruction.
- jump  input  1  control-unit Jump for current instruction.
- program_counter  output  PC_WIDTH  fetch address.
- fetch_valid  output  1  high while in RUN; core results are meaningful.
- halted  output  1  high in HALT.
- instr_count  output  16  retired instructions, saturating.

Behaviour:
- Reset (reset_n low, async): state=IDLE, program_counter=RESET_PC, fetch_valid=0, halted=0, instr_count=0. Reset asserted mid-RUN aborts immediately, with no partial update.
- States: IDLE, RUN, HALT; fetch_valid=(state==RUN), halted=(state==HALT), both registered-state decodes.
- IDLE: start=1 at edge -> RUN, program_counter=RESET_PC, instr_count=0. Otherwise hold.
- RUN, stall=1: PC, state and instr_count hold; start is ignored.
- RUN, stall=0, evaluated at each edge with priority:
  1. instruction[31:26]==HALT_OPCODE -> HALT. PC holds at the halt address. instr_count+1 (halt instruction counts). Branch and jump are ignored.
  2. jump=1 -> PC <= instruction[PC_WIDTH-1:0] (low bits of 26-bit target, word index).
  3. branch=1 and zero=1 -> PC <= PC + 1 + sign_ext(instruction[15:0]), truncated to PC_WIDTH (two's-complement wrap).
  4. otherwise PC <= PC + 1, modulo 2^PC_WIDTH. Max PC wraps to 0 and execution continues.
  - instr_count+1 for cases 2-4.
- Branch with zero=0 is a normal sequential step. jump and branch both high: jump wins.
- start held high in RUN: ignored.
- HALT: holds all outputs. start=1 at edge -> RUN, PC=RESET_PC, instr_count=0.
- instr_count saturates at 16'hFFFF and never wraps.
- Latency: a redirect computed from the instruction at PC appears on program_counter one clock after the edge. There is no delay slot.
- All outputs come directly from registers or state decode, with no combinational path from inputs to outputs.

Optional Feature:
- Macro PC_REDIRECT_COUNT_EN.
- Defined: extra output port redirect_count [15:0]. Reset to 0, cleared on start from IDLE/HALT, +1 on each non-stalled RUN cycle taking case 2 or case 3, saturates at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset/start: reset_n low -> PC=0, fetch_valid=0. Release, start=1 one cycle -> RUN, PC=0. Three non-branch instructions -> PC 1,2,3; instr_count=3.
- Branch: at PC=4, branch=1, zero=1, imm=16'hFFFD -> PC=2. Repeat with zero=0 -> PC=5. Imm=16'h0003 at PC=250 -> PC=254.
- Jump priority: PC=10, jump=1, branch=1, zero=1, instruction[7:0]=8'h40 -> PC=8'h40. redirect_count +1 when PC_REDIRECT_COUNT_EN is defined.
- Stall/wrap: PC=8'hFF with stall=1 for 3 cycles -> PC stays FF, count unchanged. Release -> PC=0, count+1.
- Halt/restart: opcode 6'h3F at PC=7 -> halted=1, fetch_valid=0, PC=7 held for 5 cycles. start=1 -> RUN, PC=0, instr_count=0.
- Async reset mid-run: reset_n low between edges while PC=12 -> outputs go to reset values before the next edge.
